// File: rtl/imem_prog_loader_pkg.sv
// rtl/imem_prog_loader_pkg.sv - shared types and constants for the instruction-memory loader
package loader_pkg;
  localparam int         INSTR_W  = 9;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_INSTR_LO,
    ST_INSTR_HI,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;
endpackage

// File: rtl/imem_prog_loader_if.sv
// rtl/imem_prog_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_prog_loader_if
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_prog_loader_checksum.sv
// rtl/imem_prog_loader_checksum.sv - 8-bit running XOR over the frame body
module frame_checksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic       match_o
);
  logic [7:0] sum_q;
  logic [7:0] sum_d;

  // clear wins so the header byte never contributes to the sum
  always_comb begin
    sum_d = sum_q;
    if (clr_i)     sum_d = 8'h00;
    else if (en_i) sum_d = sum_q ^ data_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum_q <= 8'h00;
    else        sum_q <= sum_d;
  end

  assign match_o = (sum_q == data_i);
endmodule

// File: rtl/imem_prog_loader.sv
// rtl/imem_prog_loader.sv - frames a byte stream into 9-bit instruction writes,
// holds the CPU until the frame checksum verifies
module imem_prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                reset,
  imem_prog_loader_if.slave   bus,
  input  logic                err_clr,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err
);
  state_e             state_q;
  logic [15:0]        len_q;
  logic [15:0]        idx_q;
  logic [7:0]         lo_q;
  logic               in_ready_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] wdata_q;
  logic               hold_q;
  logic               done_q;
  logic               err_q;

  logic        accept_d;
  logic        hdr_d;
  logic [15:0] len_d;
  logic [15:0] idx_d;
  logic        sum_en_d;
  logic        sum_clr_d;
  logic        sum_match;

  assign accept_d  = bus.in_valid && in_ready_q;
  assign hdr_d     = accept_d && (bus.in_data == HDR_BYTE)
                     && (state_q == ST_IDLE || state_q == ST_DONE);
  assign len_d     = {bus.in_data, len_q[7:0]};
  assign idx_d     = idx_q + 16'd1;
  assign sum_clr_d = hdr_d;
  assign sum_en_d  = accept_d && (state_q == ST_LEN_LO || state_q == ST_LEN_HI ||
                                  state_q == ST_INSTR_LO || state_q == ST_INSTR_HI);

  frame_checksum u_checksum (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (sum_clr_d),
    .en_i    (sum_en_d),
    .data_i  (bus.in_data),
    .match_o (sum_match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      lo_q       <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // the write cycle is the only one that drops ready
      we_q       <= 1'b0;
      in_ready_q <= 1'b1;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (hdr_d) begin
            state_q <= ST_LEN_LO;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            idx_q   <= '0;
          end
        end
        ST_LEN_LO: begin
          if (accept_d) begin
            len_q[7:0] <= bus.in_data;
            state_q    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept_d) begin
            len_q <= len_d;
            if (len_d > 16'(DEPTH)) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= ST_CHECK;
            end else begin
              state_q <= ST_INSTR_LO;
            end
          end
        end
        ST_INSTR_LO: begin
          if (accept_d) begin
            lo_q    <= bus.in_data;
            state_q <= ST_INSTR_HI;
          end
        end
        ST_INSTR_HI: begin
          if (accept_d) begin
            if (bus.in_data[7:1] != 7'd0) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end else begin
              we_q       <= 1'b1;
              in_ready_q <= 1'b0;
              addr_q     <= idx_q[ADDR_W-1:0];
              wdata_q    <= {bus.in_data[0], lo_q};
              idx_q      <= idx_d;
              state_q    <= (idx_d == len_q) ? ST_CHECK : ST_INSTR_LO;
            end
          end
        end
        ST_CHECK: begin
          if (accept_d) begin
            if (sum_match) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        ST_ERROR: begin
          if (err_clr) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign load_done      = done_q;
  assign load_err       = err_q;
endmodule

// File: tb/tb_imem_prog_loader.sv
// tb/tb_imem_prog_loader.sv - directed self-checking bench for imem_prog_loader
module tb_imem_prog_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic err_clr = 1'b0;
  logic cpu_hold, load_done, load_err;

  int errors = 0;
  int checks = 0;

  imem_prog_loader_if #(.ADDR_W(8)) bus ();

  imem_prog_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_clr   (err_clr),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  logic [7:0] wr_addr [0:63];
  logic [8:0] wr_data [0:63];
  int  wr_n = 0;
  int  viol = 0;
  bit  mon_en = 1'b0;
  bit  gaps = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.imem_we && wr_n < 64) begin
        wr_addr[wr_n] = bus.imem_addr;
        wr_data[wr_n] = bus.imem_wdata;
        wr_n++;
      end
      if (mon_en && (bus.imem_we === bus.in_ready)) viol++;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("handshake_timeout", 16'd0, 16'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f [], input int n);
    for (int i = 0; i < n; i++) send_byte(f[i]);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  logic [7:0] fr [];
  int base;

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("rst_we", 16'(bus.imem_we), 16'd0);
    chk("rst_addr", 16'(bus.imem_addr), 16'd0);
    chk("rst_wdata", 16'(bus.imem_wdata), 16'd0);
    chk("rst_hold", 16'(cpu_hold), 16'd1);
    chk("rst_done", 16'(load_done), 16'd0);
    chk("rst_err", 16'(load_err), 16'd0);
    reset = 1'b1;
    #1 chk("ready_before_first_edge", 16'(bus.in_ready), 16'd0);
    @(negedge clk);
    chk("ready_after_reset", 16'(bus.in_ready), 16'd1);
    mon_en = 1'b1;

    // 1: good three-instruction frame
    base = wr_n;
    fr = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h4A, 8'h01, 8'hFF, 8'h00, 8'hB6};
    send_frame(fr, 9);
    chk("t1_done_before_cs", 16'(load_done), 16'd0);
    chk("t1_hold_before_cs", 16'(cpu_hold), 16'd1);
    send_byte(fr[9]);
    chk("t1_done", 16'(load_done), 16'd1);
    chk("t1_hold", 16'(cpu_hold), 16'd0);
    chk("t1_err", 16'(load_err), 16'd0);
    chk("t1_nwr", 16'(wr_n - base), 16'd3);
    chk("t1_a0", 16'(wr_addr[base]), 16'h000);
    chk("t1_d0", 16'(wr_data[base]), 16'h001);
    chk("t1_a1", 16'(wr_addr[base+1]), 16'h001);
    chk("t1_d1", 16'(wr_data[base+1]), 16'h14A);
    chk("t1_a2", 16'(wr_addr[base+2]), 16'h002);
    chk("t1_d2", 16'(wr_data[base+2]), 16'h0FF);

    // 2: same frame, bad checksum
    base = wr_n;
    fr[9] = 8'h00;
    send_frame(fr, 10);
    chk("t2_nwr", 16'(wr_n - base), 16'd3);
    chk("t2_d2", 16'(wr_data[base+2]), 16'h0FF);
    chk("t2_err", 16'(load_err), 16'd1);
    chk("t2_hold", 16'(cpu_hold), 16'd1);
    chk("t2_done", 16'(load_done), 16'd0);
    pulse_err_clr();
    chk("t2_err_cleared", 16'(load_err), 16'd0);
    chk("t2_hold_after_clr", 16'(cpu_hold), 16'd1);

    // 3: length above DEPTH
    base = wr_n;
    fr = '{8'hA5, 8'h01, 8'h01};
    send_frame(fr, 3);
    chk("t3_err_after_lenhi", 16'(load_err), 16'd1);
    fr = '{8'hA5, 8'h01, 8'h00, 8'h05, 8'h01, 8'h05};
    send_frame(fr, 6);
    chk("t3_ignored_nwr", 16'(wr_n - base), 16'd0);
    chk("t3_still_err", 16'(load_err), 16'd1);
    chk("t3_not_done", 16'(load_done), 16'd0);
    pulse_err_clr();
    send_frame(fr, 6);
    chk("t3_after_clr_nwr", 16'(wr_n - base), 16'd1);
    chk("t3_after_clr_d0", 16'(wr_data[base]), 16'h105);
    chk("t3_after_clr_done", 16'(load_done), 16'd1);

    // 4: illegal HI byte
    base = wr_n;
    fr = '{8'hA5, 8'h01, 8'h00, 8'h33, 8'h02};
    send_frame(fr, 5);
    repeat (2) @(negedge clk);
    chk("t4_err", 16'(load_err), 16'd1);
    chk("t4_nwr", 16'(wr_n - base), 16'd0);
    chk("t4_hold", 16'(cpu_hold), 16'd1);
    pulse_err_clr();

    // 5: garbage then a gappy one-instruction frame
    base = wr_n;
    gaps = 1'b1;
    fr = '{8'h00, 8'h11, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h7E, 8'h00, 8'h7F};
    send_frame(fr, 9);
    gaps = 1'b0;
    chk("t5_nwr", 16'(wr_n - base), 16'd1);
    chk("t5_a0", 16'(wr_addr[base]), 16'h000);
    chk("t5_d0", 16'(wr_data[base]), 16'h07E);
    chk("t5_done", 16'(load_done), 16'd1);
    chk("t5_hold", 16'(cpu_hold), 16'd0);

    // 6: reset during the first write cycle, then full reload
    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h01};
    send_frame(fr, 5);
    chk("t6_we_before_rst", 16'(bus.imem_we), 16'd1);
    #1;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_rst_hold", 16'(cpu_hold), 16'd1);
    chk("t6_rst_done", 16'(load_done), 16'd0);
    chk("t6_rst_we", 16'(bus.imem_we), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    base = wr_n;
    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h01, 8'h22, 8'h00, 8'h30};
    send_frame(fr, 8);
    chk("t6_nwr", 16'(wr_n - base), 16'd2);
    chk("t6_a0", 16'(wr_addr[base]), 16'h000);
    chk("t6_d0", 16'(wr_data[base]), 16'h111);
    chk("t6_a1", 16'(wr_addr[base+1]), 16'h001);
    chk("t6_d1", 16'(wr_data[base+1]), 16'h022);
    chk("t6_done", 16'(load_done), 16'd1);
    chk("t6_hold", 16'(cpu_hold), 16'd0);

    chk("ready_only_low_on_write", 16'(viol), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream, assembles 9-bit instructions and writes them to consecutive instruction-memory addresses starting at 0.
- Holds the processor while loading and releases it only after the frame checksum verifies.
- Replaces direct hierarchical preloading of instruction memory with a real load path.
- Sits between a host byte source (UART/bench driver) and the instruction memory write port plus the processor hold input.

Parameters:
- INSTR_W, 9, instruction width; fixed by the ISA.
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of instruction memory words; a frame length above DEPTH is an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte. A byte transfers when in_valid and in_ready are both high on a rising clk.
- err_clr  in  1  single-cycle pulse; leaves ERROR.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  INSTR_W  write data.
- cpu_hold  out  1  processor stall/hold; high means the processor must not fetch.
- load_done  out  1  last frame verified OK.
- load_err  out  1  sticky frame error.

Behaviour:
Reset values (reset low, asynchronous):
- State IDLE; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0.
- cpu_hold=1; load_done=0; load_err=0.
- Counters and checksum cleared.
- in_ready rises in the first cycle after reset deasserts.

Frame format:
- Header 0xA5.
- LEN_LO, LEN_HI: 16-bit instruction count N.
- N pairs of {LO = instr[7:0], HI = {7'b0, instr[8]}}.
- One checksum byte equal to the XOR of every byte after the header, up to and excluding the checksum.

States and transitions:
- IDLE: non-0xA5 bytes are accepted and discarded. 0xA5 -> LEN_LO; on acceptance set cpu_hold=1, clear load_done, clear checksum.
- LEN_LO -> LEN_HI. Then if N > DEPTH -> ERROR; if N == 0 -> CHECK; else -> INSTR_LO.
- INSTR_LO -> INSTR_HI. If the HI byte bits[7:1] are nonzero -> ERROR.
  - Otherwise, in the cycle after HI is accepted: imem_we=1 for exactly one cycle, imem_addr = instruction index, imem_wdata = {HI[0], LO}.
  - The index increments after each write. If the index == N -> CHECK, else -> INSTR_LO.
- CHECK: on checksum acceptance, match -> DONE; mismatch -> ERROR.
- DONE: load_done=1 and cpu_hold=0 from the cycle after the checksum is accepted. Behaves as IDLE; a new 0xA5 restarts loading.
- ERROR: load_err=1 and cpu_hold stays 1. in_ready=1 and all bytes are discarded. On err_clr, go to IDLE and clear load_err; cpu_hold stays 1.

Handshake and timing:
- in_ready=1 in every state except the single cycle in which imem_we is asserted. This gives one bubble per instruction, so no write and acceptance ever coincide.
- Throughput: one byte per cycle otherwise.
- Address is index[ADDR_W-1:0]. It never wraps, because N ≤ DEPTH is enforced.

Partial frames and resets:
- A partially loaded frame leaves the already-written words in memory. The processor is not released.
- Reset mid-frame aborts the frame; outputs return to reset values.
- err_clr in any state other than ERROR is ignored.
- in_valid low simply stalls; there is no timeout.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum type;
  - constant HDR_BYTE = 8'hA5;
  - INSTR_W, to match the processor package.
- One natural sub-module: frame_checksum (8-bit running XOR with clear/enable/compare).
- The FSM, counters and write-port registers stay in the top level.

Test Plan:
1. Reset, then send frame A5 03 00 01 00 4A 01 FF 00 CS (CS = XOR of the bytes from 03 through 00 = 0xB6).
   - Required: writes addr0=9'h001, addr1=9'h14A, addr2=9'h0FF, each a single-cycle imem_we.
   - load_done=1 and cpu_hold=0 one cycle after CS is accepted.
2. Same frame with CS=0x00.
   - Required: all three writes occur, load_err=1, cpu_hold stays 1.
   - err_clr pulse clears load_err; cpu_hold remains 1.
3. Frame with LEN=0x0101 (257 > DEPTH).
   - Required: ERROR immediately after LEN_HI, no imem_we.
   - A subsequent valid frame is ignored until err_clr is pulsed.
4. Frame with HI byte 0x02 in the first instruction.
   - Required: ERROR, no write to addr0.
5. Garbage bytes 00 11 FF, then a valid 1-instruction frame with random in_valid gaps.
   - Required: garbage is discarded and the single write is correct.
   - in_ready is low only in the imem_we cycle.
6. Reset asserted in the middle of the instruction payload, then a full reload.
   - Required: immediate cpu_hold=1, load_done=0, imem_we=0.
   - Reload succeeds from addr0.
